// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the RV32M iterative multiply/divide unit.
//   XLEN            operand/result width (only 32 is supported)
//   muldiv_op_e     the eight funct3 encodings of the M extension
//   muldiv_state_e  control states of the unit
//   is_div / is_rem / is_signed_a / is_signed_b  operation class predicates
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide beside the register file.
// A start in IDLE latches op, operands and rd_addr; the operation then runs
// 32 iterations (or finishes in one cycle for the divide special cases) and
// issues a single-cycle write-back.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, op             request and funct3 (sampled only in IDLE)
//   rs1_data, rs2_data    operands A and B
//   rd_addr               destination register index
//   busy                  high in CALC and DONE (core stall)
//   done                  one-cycle completion pulse
//   wb_enable             done with a non-zero destination
//   wb_addr, wb_data      latched destination and result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic            wb_enable,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  muldiv_state_e     state, state_next;
  muldiv_op_e        op_in, op_q;
  logic [4:0]        count;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc, acc_step, product;
  logic              neg_res, neg_rem;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              special;
  logic [XLEN-1:0]   special_data;
  logic [XLEN:0]     sum, diff;
  logic [XLEN-1:0]   quot, remv, result;

  assign op_in = muldiv_op_e'(op);

  // Operand preparation at accept time: effective signs, magnitudes and the
  // divide cases that bypass the iterative datapath.
  always_comb begin
    sign_a       = is_signed_a(op_in) & rs1_data[XLEN-1];
    sign_b       = is_signed_b(op_in) & rs2_data[XLEN-1];
    abs_a        = sign_a ? -rs1_data : rs1_data;
    abs_b        = sign_b ? -rs2_data : rs2_data;
    special      = 1'b0;
    special_data = '0;
    if (is_div(op_in)) begin
      if (rs2_data == '0) begin
        special      = 1'b1;
        special_data = is_rem(op_in) ? rs1_data : {XLEN{1'b1}};
      end else if (is_signed_a(op_in) && rs1_data == {1'b1, {(XLEN-1){1'b0}}} &&
                   rs2_data == {XLEN{1'b1}}) begin
        special      = 1'b1;
        special_data = is_rem(op_in) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
    end
  end

  // One iteration. Multiply: acc = {partial product, remaining multiplier
  // bits}, add mag_a on the multiplier LSB then shift right. Divide:
  // acc = {partial remainder, dividend/quotient bits}; the 33-bit shifted
  // remainder is trial-subtracted and the borrow selects the quotient bit.
  always_comb begin
    sum      = '0;
    diff     = '0;
    acc_step = acc;
    if (is_div(op_q)) begin
      diff = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
      if (diff[XLEN])
        acc_step = {acc[2*XLEN-2:0], 1'b0};
      else
        acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
      acc_step = {sum, acc[XLEN-1:1]};
    end
  end

  // Final sign fix-up applied to the value produced by the last iteration.
  always_comb begin
    product = neg_res ? -acc_step : acc_step;
    quot    = acc_step[XLEN-1:0];
    remv    = acc_step[2*XLEN-1:XLEN];
    if (is_div(op_q))
      result = is_rem(op_q) ? (neg_rem ? -remv : remv) : (neg_res ? -quot : quot);
    else
      result = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? DONE : CALC;
      CALC:    if (count == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe. On the IDLE->DONE path wb_addr is loaded on
  // the same edge, so rd_addr decides wb_enable there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_enable <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      count     <= '0;
      op_q      <= OP_MUL;
      mag_a     <= '0;
      mag_b     <= '0;
      acc       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      wb_enable <= (state_next == DONE) &&
                   (((state == IDLE) ? rd_addr : wb_addr) != 5'd0);
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op_in;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            acc     <= is_div(op_in) ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            wb_addr <= rd_addr;
            count   <= '0;
            if (special) wb_data <= special_data;
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + 5'd1;
          if (count == 5'd31) wb_data <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed cases with
// known results, a mid-flight start, a mid-flight reset, then randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done, wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int check_count = 0;
  int pass_count  = 0;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .wb_enable (wb_enable),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference results from the RV32M definitions using plain 64-bit math.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa = longint'(signed'(a));
    longint     sb = longint'(signed'(b));
    longint     ua = longint'({32'b0, a});
    longint     ub = longint'({32'b0, b});
    longint     r;
    logic [63:0] p;
    case (o)
      3'b000: begin r = sa * sb; return r[31:0]; end
      3'b001: begin r = sa * sb; return r[63:32]; end
      3'b010: begin r = sa * ub; return r[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; return r[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = ua / ub; return r[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb; return r[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = ua % ub; return r[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation and follow it to its write-back. inject_at > 0 pulses
  // a second start with different operands in that cycle after acceptance.
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] exp_data, input int inject_at);
    int   lat     = 0;
    logic busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    rd_addr = 5'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (done) begin lat = k; break; end
      if (!busy) busy_ok = 1'b0;
      start = (k == inject_at);
      if (k == inject_at) begin
        op = 3'b011; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_addr = 5'd9;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({name, " latency"}, 64'(lat), 64'(ref_latency(o, a, b)));
    checkOutput({name, " busy_calc"}, 64'(busy_ok), 64'd1);
    checkOutput({name, " busy_done"}, 64'(busy), 64'd1);
    checkOutput({name, " wb_data"}, 64'(wb_data), 64'(exp_data));
    checkOutput({name, " wb_addr"}, 64'(wb_addr), 64'(rd));
    checkOutput({name, " wb_enable"}, 64'(wb_enable), 64'(rd != 5'd0));
    @(negedge clk);
    checkOutput({name, " done_after"}, 64'(done), 64'd0);
    checkOutput({name, " busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic resetMidFlight;
    logic seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs1_data = 32'd11; rs2_data = 32'd13; rd_addr = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 12; k++) @(negedge clk);
    checkOutput("rst busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst done", 64'(done), 64'd0);
    checkOutput("rst wb_enable", 64'(wb_enable), 64'd0);
    checkOutput("rst wb_data", 64'(wb_data), 64'd0);
    checkOutput("rst wb_addr", 64'(wb_addr), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || wb_enable) seen_done = 1'b1;
    end
    checkOutput("rst no_done", 64'(seen_done), 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_rd;
    rst_n = 1'b0; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset wb_enable", 64'(wb_enable), 64'd0);
    checkOutput("reset wb_addr", 64'(wb_addr), 64'd0);
    checkOutput("reset wb_data", 64'(wb_data), 64'd0);
    rst_n = 1'b1;

    applyStimulus("mul_7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    applyStimulus("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 0);
    applyStimulus("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 0);
    applyStimulus("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 0);
    applyStimulus("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, 0);
    applyStimulus("div_-7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 0);
    applyStimulus("rem_-7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 0);
    applyStimulus("divu_-7/2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'h7FFF_FFFC, 0);
    applyStimulus("remu_-7/2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'h0000_0001, 0);
    applyStimulus("div_5/0", OP_DIV, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 0);
    applyStimulus("remu_5/0", OP_REMU, 32'd5, 32'd0, 5'd15, 32'h0000_0005, 0);
    applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0);
    applyStimulus("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 0);
    applyStimulus("start_ignored", OP_MUL, 32'd100, 32'd3, 5'd18, 32'd300, 10);
    applyStimulus("rd_zero", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 0);
    resetMidFlight();
    applyStimulus("after_reset", OP_REMU, 32'd100, 32'd7, 5'd1, 32'd2, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2:       r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      r_rd = 5'($urandom);
      applyStimulus("random", r_op, r_a, r_b, r_rd, ref_model(r_op, r_a, r_b), 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit beside the register file of the RV32I core. It takes the two register read operands and the destination index for an M-extension instruction. It computes over 32 cycles, holding `busy` so the core stalls. It then drives a one-cycle write-back (`wb_enable`, `wb_data`, `wb_addr`) straight into the register file write port.

## Interface
Parameters:
- `XLEN`, default 32. Operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data`  in  32  operand A (register read port 1)
- `rs2_data`  in  32  operand B (register read port 2)
- `rd_addr`  in  5  destination register index
- `busy`  out  1  high in CALC and DONE; core stalls
- `done`  out  1  one-cycle completion pulse
- `wb_enable`  out  1  `done && wb_addr != 0`; drives regfile write enable
- `wb_addr`  out  5  latched `rd_addr`
- `wb_data`  out  32  result; holds until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start=1` latches `op`, operands and `rd_addr`.
  - Special case → DONE directly. Otherwise → CALC with counter = 0.
- Special cases, all 1-cycle:
  - DIV/DIVU with B=0: quotient = 0xFFFFFFFF.
  - REM/REMU with B=0: remainder = A.
  - DIV with A=0x80000000, B=0xFFFFFFFF: quotient = 0x80000000; REM of the same operands = 0.
- CALC runs exactly 32 iterations; the 5-bit counter wraps 31→0 on exit, then → DONE.
- DONE lasts one cycle: `done=1`, `wb_data` valid, then → IDLE. `start` in CALC or DONE is ignored; no queuing.
- Multiply:
  - Take magnitudes of the signed operands: MUL/MULH both signed, MULHSU A only, MULHU none.
  - 32 shift-add steps into a 64-bit accumulator.
  - Negate the 64-bit product if the effective signs differ.
  - MUL returns bits [31:0]; the MULH variants return [63:32].
- Divide:
  - Magnitudes for signed ops (DIV/REM); restoring division, one quotient bit per iteration, 33-bit partial remainder.
  - Quotient is negated when signs differ; remainder takes the sign of the dividend.
- `rd_addr=0`: full computation runs and `done` pulses, but `wb_enable` stays 0.

## Timing
- Reset values: state IDLE; `busy`, `done`, `wb_enable` = 0; `wb_addr` = 0; `wb_data` = 0; counter and accumulators 0.
- `start` high in cycle T (IDLE), normal op:
  - CALC covers cycles T+1..T+32.
  - DONE in T+33: `done`, `wb_enable` and `wb_data` valid.
  - IDLE in T+34; the earliest next accept is T+34.
- Special case: DONE in T+1, IDLE in T+2.
- `busy` is high from T+1 through the DONE cycle inclusive; it is low in the accept cycle T itself. The core holds the instruction using `busy` from T+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs 0.
  - An in-flight result is discarded; no `done` or `wb_enable` is ever produced for it.
- Operand inputs may change after T with no effect.

## Structure
- Shared package `muldiv_pkg`:
  - `XLEN` constant.
  - `muldiv_op_e` enum of the eight funct3 encodings.
  - `muldiv_state_e` enum {IDLE, CALC, DONE}.
  - Helper predicates `is_div(op)` and `is_signed_a/b(op)`.
- Single module, no sub-module: multiply and divide share the counter, operand-magnitude registers and the final negate logic.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5, start at T → `busy` T+1..T+33; at T+33 `done=1`, `wb_enable=1`, `wb_addr=5`, `wb_data=0xFFFFFFEB`.
- A=B=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
  - MUL → 0x00000001
- Division:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD
  - REM same → 0xFFFFFFFF
  - DIVU same → 0x7FFFFFFC
  - REMU same → 0x00000001
- Special cases, each with `done` at T+1:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 0x00000005
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM same → 0
- Handshake and reset:
  - Second `start` pulsed at T+10 with different operands → ignored; the result matches the first op only.
  - rd=0 → `done` pulses, `wb_enable` stays 0.
  - `rst_n=0` at T+12 → IDLE and `busy=0` at T+13; no `done` pulse afterwards.
